// File: rtl/pwm_note_decoder.sv
`default_nettype none
// ============================================================================
// Module   : pwm_note_decoder
// Brief    : Measures period and high time of a PWM/square-wave audio line
//            and turns the period into a debounced 5-bit note code
//            (1..7 = do..si, 0 = silence/unknown).
// Revision : 1.0 - initial release
// ============================================================================
module pwm_note_decoder #(
    parameter int unsigned TIMEOUT    = 500000,
    parameter int unsigned STABLE_N   = 3,
    parameter int unsigned MIN_PERIOD = 180000,
    parameter int unsigned MAX_PERIOD = 430000,
    // Lower period bound of each note band (do is the longest period)
    parameter int unsigned TH_DO      = 361431,
    parameter int unsigned TH_RE      = 321998,
    parameter int unsigned TH_MI      = 294883,
    parameter int unsigned TH_FA      = 270735,
    parameter int unsigned TH_SO      = 241187,
    parameter int unsigned TH_LA      = 214891
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pwm_in,
    input  logic        en,
    output logic [4:0]  note,
    output logic        note_valid,
    output logic [19:0] period,
    output logic [19:0] high_time,
    output logic        sd
);

    localparam logic [19:0] c_timeout  = 20'(TIMEOUT);
    localparam logic [19:0] c_min      = 20'(MIN_PERIOD);
    localparam logic [19:0] c_max      = 20'(MAX_PERIOD);
    localparam logic [19:0] c_th_do    = 20'(TH_DO);
    localparam logic [19:0] c_th_re    = 20'(TH_RE);
    localparam logic [19:0] c_th_mi    = 20'(TH_MI);
    localparam logic [19:0] c_th_fa    = 20'(TH_FA);
    localparam logic [19:0] c_th_so    = 20'(TH_SO);
    localparam logic [19:0] c_th_la    = 20'(TH_LA);
    localparam logic [3:0]  c_stable_n = 4'(STABLE_N);

    localparam logic [1:0]  c_st_idle    = 2'd0;
    localparam logic [1:0]  c_st_armed   = 2'd1;
    localparam logic [1:0]  c_st_measure = 2'd2;

    logic        r_sync1;
    logic        r_sync2;
    logic        r_prev;
    logic        w_rise;
    logic [19:0] r_cnt;
    logic [19:0] r_hcnt;
    logic [1:0]  r_state;
    logic [3:0]  r_scnt;
    logic [4:0]  r_cand;
    logic [4:0]  r_note;
    logic        r_note_valid;
    logic [19:0] r_period;
    logic [19:0] r_high_time;
    logic        r_sd;
    logic [4:0]  w_code;
    logic [3:0]  w_scnt_next;
    logic        w_update;

    assign note       = r_note;
    assign note_valid = r_note_valid;
    assign period     = r_period;
    assign high_time  = r_high_time;
    assign sd         = r_sd;

    // Two-flop synchronizer for the asynchronous pin plus one flop for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= pwm_in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign w_rise = r_sync2 & ~r_prev;

    // Period and high-time counters, restarted by each rising edge, saturating at the timeout
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= 20'd0;
            r_hcnt <= 20'd0;
        end else if (!en) begin
            r_cnt  <= 20'd0;
            r_hcnt <= 20'd0;
        end else if (w_rise) begin
            r_cnt  <= 20'd1;
            r_hcnt <= 20'd1;
        end else begin
            if (r_cnt != c_timeout) begin
                r_cnt <= r_cnt + 20'd1;
            end
            if (r_sync2 && (r_hcnt != c_timeout)) begin
                r_hcnt <= r_hcnt + 20'd1;
            end
        end
    end

    // Map the period ending at this edge onto a note band; out-of-range periods are code 0
    always_comb begin
        w_code = 5'd0;
        if ((r_cnt < c_min) || (r_cnt > c_max)) begin
            w_code = 5'd0;
        end else if (r_cnt >= c_th_do) begin
            w_code = 5'd1;
        end else if (r_cnt >= c_th_re) begin
            w_code = 5'd2;
        end else if (r_cnt >= c_th_mi) begin
            w_code = 5'd3;
        end else if (r_cnt >= c_th_fa) begin
            w_code = 5'd4;
        end else if (r_cnt >= c_th_so) begin
            w_code = 5'd5;
        end else if (r_cnt >= c_th_la) begin
            w_code = 5'd6;
        end else begin
            w_code = 5'd7;
        end
    end

    // Debounce: run length of identical codes, saturating at 15; a new code restarts it at 1
    always_comb begin
        w_scnt_next = 4'd1;
        if (w_code == r_cand) begin
            w_scnt_next = (r_scnt == 4'd15) ? 4'd15 : (r_scnt + 4'd1);
        end
        w_update = (w_scnt_next >= c_stable_n) && (w_code != r_note);
    end

    // Arm/measure state machine with capture, debounced note update and silence timeout
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_st_idle;
            r_scnt       <= 4'd0;
            r_cand       <= 5'd0;
            r_note       <= 5'd0;
            r_note_valid <= 1'b0;
            r_period     <= 20'd0;
            r_high_time  <= 20'd0;
            r_sd         <= 1'b0;
        end else begin
            r_note_valid <= 1'b0;
            if (!en) begin
                r_state <= c_st_idle;
                r_scnt  <= 4'd0;
            end else if (w_rise) begin
                // A rise wins over a coincident timeout: the saturated count is captured instead
                if (r_state == c_st_idle) begin
                    r_state <= c_st_armed;
                end else begin
                    r_state     <= c_st_measure;
                    r_period    <= r_cnt;
                    r_high_time <= r_hcnt;
                    r_cand      <= w_code;
                    r_scnt      <= w_scnt_next;
                    if (w_update) begin
                        r_note       <= w_code;
                        r_sd         <= (w_code != 5'd0);
                        r_note_valid <= 1'b1;
                    end
                end
            end else if (r_cnt == c_timeout) begin
                r_state <= c_st_idle;
                r_scnt  <= 4'd0;
                if (r_note != 5'd0) begin
                    r_note       <= 5'd0;
                    r_sd         <= 1'b0;
                    r_note_valid <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire
